// File: rtl/reg_bank_combiner.sv
// ---------------------------------------------------------------------------
// reg_bank_combiner
//
// Purpose:
//   Front-panel register bank. An operator dials a value on the switches
//   (i_data_in) and presses the bouncy "load" button (i_ld) to store it in the
//   entry selected by the pointer. The "advance" button (i_inc) steps the
//   pointer. Once every entry holds a non-zero value, the block switches to
//   combine mode. In combine mode the display shows a reduction of all
//   entries, selected by i_mode. A further press of i_inc clears the bank and
//   returns the block to fill mode.
//
// Parameters:
//   WIDTH      - bit width of each entry, of i_data_in and of o_data_out
//   DEPTH      - number of entries (2..16)
//   DEB_CYCLES - consecutive disagreeing cycles before the debounced load
//                level follows the raw button (>= 1)
//   PTR_W      - pointer width, derived from DEPTH (do not override)
//
// Ports:
//   i_clk      - system clock, rising edge
//   i_rst_n    - asynchronous active-low reset
//   i_data_in  - value written into the current entry on a load
//   i_ld       - raw load button level (may bounce)
//   i_inc      - raw advance / clear button level
//   i_mode     - combine function: 00 OR, 01 AND, 10 XOR, 11 SUM mod 2^WIDTH
//   o_data_out - displayed value (entry under the pointer, or the reduction)
//   o_full     - high while in combine mode
//   o_ptr      - current entry pointer
// ---------------------------------------------------------------------------
module reg_bank_combiner #(
    parameter int WIDTH      = 4,
    parameter int DEPTH      = 3,
    parameter int DEB_CYCLES = 4,
    parameter int PTR_W      = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_data_in,
    input  logic             i_ld,
    input  logic             i_inc,
    input  logic [1:0]       i_mode,
    output logic [WIDTH-1:0] o_data_out,
    output logic             o_full,
    output logic [PTR_W-1:0] o_ptr
);

    localparam int                CNT_W    = $clog2(DEB_CYCLES + 1);
    localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(DEPTH - 1);
    // The debounced level toggles on the cycle the counter would reach
    // DEB_CYCLES, so the compare is against DEB_CYCLES-1.
    localparam logic [CNT_W-1:0]  DEB_LAST = CNT_W'(DEB_CYCLES - 1);

    typedef enum logic {
        S_FILL,
        S_COMBINE
    } state_t;

    state_t           r_state;
    state_t           w_stateNext;

    logic [WIDTH-1:0] r_entry [DEPTH];
    logic [PTR_W-1:0] r_ptr;
    logic [WIDTH-1:0] r_outReg;
    logic [WIDTH-1:0] r_resReg;

    logic             r_incD;
    logic             w_incPulse;

    logic [CNT_W-1:0] r_debCnt;
    logic             r_ldDeb;
    logic             r_ldDebD;
    logic             w_ldPulse;

    logic [PTR_W-1:0] w_ptrNext;
    logic             w_allNonZero;
    logic [WIDTH-1:0] w_orAll;
    logic [WIDTH-1:0] w_andAll;
    logic [WIDTH-1:0] w_xorAll;
    logic [WIDTH-1:0] w_sumAll;
    logic [WIDTH-1:0] w_reduced;

    // ------------------------------------------------------------------
    // Advance button: a single-cycle pulse on each rising edge, however
    // long the button is held down.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_incD <= 1'b0;
        end else begin
            r_incD <= i_inc;
        end
    end

    assign w_incPulse = i_inc & ~r_incD;

    // ------------------------------------------------------------------
    // Load button debouncer. The counter only runs while the raw level
    // disagrees with the debounced level. Any agreeing cycle restarts it,
    // so a bounce shorter than DEB_CYCLES never reaches the bank.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_debCnt <= '0;
            r_ldDeb  <= 1'b0;
            r_ldDebD <= 1'b0;
        end else begin
            r_ldDebD <= r_ldDeb;
            if (i_ld == r_ldDeb) begin
                r_debCnt <= '0;
            end else if (r_debCnt == DEB_LAST) begin
                r_ldDeb  <= ~r_ldDeb;
                r_debCnt <= '0;
            end else begin
                r_debCnt <= r_debCnt + 1'b1;
            end
        end
    end

    assign w_ldPulse = r_ldDeb & ~r_ldDebD;

    // ------------------------------------------------------------------
    // Pointer increment with wrap at the last entry. The wrap also works
    // when DEPTH is not a power of two.
    // ------------------------------------------------------------------
    always_comb begin
        w_ptrNext = r_ptr + 1'b1;
        if (r_ptr == LAST_PTR) begin
            w_ptrNext = '0;
        end
    end

    // ------------------------------------------------------------------
    // Reductions over the whole bank. The "all non-zero" flag is computed
    // here as well, because it is what triggers combine mode. An entry
    // loaded with zero therefore still counts as empty.
    // ------------------------------------------------------------------
    always_comb begin
        w_orAll      = '0;
        w_andAll     = '1;
        w_xorAll     = '0;
        w_sumAll     = '0;
        w_allNonZero = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            w_orAll  = w_orAll | r_entry[k];
            w_andAll = w_andAll & r_entry[k];
            w_xorAll = w_xorAll ^ r_entry[k];
            w_sumAll = w_sumAll + r_entry[k];
            if (r_entry[k] == '0) begin
                w_allNonZero = 1'b0;
            end
        end
        case (i_mode)
            2'b00:   w_reduced = w_orAll;
            2'b01:   w_reduced = w_andAll;
            2'b10:   w_reduced = w_xorAll;
            default: w_reduced = w_sumAll;
        endcase
    end

    // ------------------------------------------------------------------
    // Mode state register.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. The bank enters combine mode as soon as it is
    // fully populated. It returns to fill mode only on an advance press.
    // ------------------------------------------------------------------
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            S_FILL: begin
                if (w_allNonZero) begin
                    w_stateNext = S_COMBINE;
                end
            end
            S_COMBINE: begin
                if (w_incPulse) begin
                    w_stateNext = S_FILL;
                end
            end
            default: w_stateNext = S_FILL;
        endcase
    end

    // ------------------------------------------------------------------
    // Bank datapath.
    //
    // In fill mode, the display register tracks the entry under the
    // pointer with one cycle of lag. On the edge that leaves fill mode,
    // any button pulse is dropped. The result register is primed on that
    // same edge, so the display is valid in the first combine cycle.
    // Advance beats load when both pulse together.
    //
    // In combine mode, the bank is frozen and the result register
    // re-reduces every cycle, so a mode change shows one cycle later.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_entry[k] <= '0;
            end
            r_ptr    <= '0;
            r_outReg <= '0;
            r_resReg <= '0;
        end else begin
            case (r_state)
                S_FILL: begin
                    r_outReg <= r_entry[r_ptr];
                    if (w_allNonZero) begin
                        r_resReg <= w_reduced;
                    end else if (w_incPulse) begin
                        r_ptr <= w_ptrNext;
                    end else if (w_ldPulse) begin
                        r_entry[r_ptr] <= i_data_in;
                        r_ptr          <= w_ptrNext;
                    end
                end
                S_COMBINE: begin
                    if (w_incPulse) begin
                        for (int k = 0; k < DEPTH; k++) begin
                            r_entry[k] <= '0;
                        end
                        r_ptr    <= '0;
                        r_resReg <= '0;
                        r_outReg <= '0;
                    end else begin
                        r_resReg <= w_reduced;
                    end
                end
                default: begin
                    r_outReg <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs come straight from registers. The display source follows
    // the mode.
    // ------------------------------------------------------------------
    assign o_full     = (r_state == S_COMBINE);
    assign o_data_out = (r_state == S_COMBINE) ? r_resReg : r_outReg;
    assign o_ptr      = r_ptr;

endmodule
